input_port_router: RTL and testbench
====================================

Name: input_port_router

Overview:
- Receive side of one router link: accepts packets arriving from a neighbour link (or local requester), buffers them in a small FIFO, XY-decodes the destination network address and requests exactly one target (NORTH/SOUTH/EAST/WEST output arbiter or LOCAL cache arbiter).
- Complements the output-port arbiter: its per-target select bits and payload feed the arbiters' selectBit_* / *In_* inputs.
- One instance per router input port.

Parameters:
- NET_ADDR_W, 4, network address width; low half = X, high half = Y.
- BANK_ADDR_W, 8, cache bank address width; bits below the network address in destAddr.
- DATA_W, 32, payload data width.
- DEPTH, 4, FIFO entries; power of two, >= 2.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- myAddr  in  NET_ADDR_W  this router's network address; static after reset
- inValid  in  1  incoming packet valid
- inReady  out  1  FIFO can accept a packet this cycle
- destAddrIn  in  NET_ADDR_W+BANK_ADDR_W  destination {netAddr, bankAddr}
- reqAddrIn  in  NET_ADDR_W  requester network address
- readIn, writeIn  in  1 each  request type
- dataIn  in  DATA_W  payload
- selectBit_NORTH, selectBit_SOUTH, selectBit_EAST, selectBit_WEST, selectLocal  out  1 each  head packet routed to that target
- grant_NORTH, grant_SOUTH, grant_EAST, grant_WEST, grantLocal  in  1 each  target consumed the head packet this cycle
- destAddrOut, reqAddrOut, readOut, writeOut, dataOut  out  same widths as inputs  head packet payload
- malformedError  out  1  sticky; exists only with PKT_CHECK_EN

Behaviour:
- Reset is synchronous and active-high on clk. It clears count and the read/write pointers to 0, inReady=1 the cycle after, all selects=0, all payload outputs=0, and malformedError=0. Reset mid-operation discards all buffered packets, with no partial output.
- Push: inValid && inReady at posedge stores the packet at wr_ptr. wr_ptr increments mod DEPTH.
- inReady = (count != DEPTH), derived from registered count only. A pop in the same cycle does not open a slot when full; there is no full-bypass.
- Head output is first-word fall-through, combinational from mem[rd_ptr]. A packet pushed at edge k appears on outputs in cycle k+1 (1-cycle latency) when the FIFO was empty.
- Route of the head packet uses dn = destAddrOut[top NET_ADDR_W bits], dx/dy = low/high halves of dn, and mx/my = halves of myAddr, compared unsigned:
  - dx > mx: EAST
  - dx < mx: WEST
  - dx == mx and dy > my: SOUTH
  - dx == mx and dy < my: NORTH
  - otherwise: LOCAL
- Exactly one select is high when count != 0; all selects are 0 and payload outputs are 0 when empty.
- Pop: the head is popped when the grant for the currently asserted select is high. rd_ptr then increments mod DEPTH. Grants on non-selected targets are ignored. Select and payload stay stable until popped.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Pointer wrap: at DEPTH-1 both pointers wrap to 0. count width is clog2(DEPTH)+1.
- Empty and a push in the same cycle: the packet is not visible until the next cycle; there is no input-to-output bypass.
- Pointers hold when neither a push nor a pop occurs.

Optional Feature:
- PKT_CHECK_EN defined: an accepted-handshake packet with readIn == writeIn (both 0 or both 1) is dropped, never stored. malformedError sets and stays 1 until reset. inReady is unaffected.
- PKT_CHECK_EN undefined: all packets are stored and routed unchanged, and the malformedError port is absent.

Decomposition:
- Shared include/package holds the width macros (network address, bank address, data) alongside the existing global defines.
- It also holds the direction encoding DIR_NORTH=0, DIR_SOUTH=1, DIR_EAST=2, DIR_WEST=3, DIR_LOCAL=4, shared with the output arbiter's select ordering.
- One natural sub-module, xy_route_decode: combinational, (myAddr, dn) -> 5-bit one-hot select.
- The FIFO stays inline.

Test Plan:
- Test 1, east route: myAddr=4'b0101 (x=1,y=1); push destAddrIn netAddr 4'b0110 (x=2,y=1) with grant_EAST held 1. Expect selectBit_EAST=1 the next cycle with payload matching, then empty one cycle later.
- Test 2, all five routes: same myAddr, netAddrs 4'b0100, 4'b1001, 4'b0001, 4'b0101. Expect WEST, SOUTH, NORTH and LOCAL respectively, with exactly one select per cycle.
- Test 3, full/backpressure: DEPTH=4, push 5 back-to-back with no grants. Expect inReady=0 after 4 accepted and the 5th held. Then grant once; expect inReady=1 the next cycle and packets exit in order.
- Test 4, simultaneous push and pop: with count=2, push and grant every cycle for 10 cycles. Expect count constant at 2, pointers to wrap twice, and in-order data 0..9.
- Test 5, wrong grant and reset: head routed WEST, assert grant_EAST only. Expect no pop. Assert reset with 3 packets buffered; expect selects=0, payload=0, and inReady=1 the next cycle.
- Test 6 (PKT_CHECK_EN): push readIn=1, writeIn=1. Expect the packet to be absent from the outputs, malformedError=1 held, and later valid packets still routed.

Source files
------------

// File: rtl/input_port_router_pkg.sv
// rtl/input_port_router_pkg.sv - shared widths and direction encoding for the router input port
package input_port_router_pkg;

  localparam int NET_ADDR_W_DEF  = 4;
  localparam int BANK_ADDR_W_DEF = 8;
  localparam int DATA_W_DEF      = 32;
  localparam int NUM_DIRS        = 5;

  // Bit positions in the select/grant vectors; matches the output arbiter's ordering.
  typedef enum logic [2:0] {
    DIR_NORTH = 3'd0,
    DIR_SOUTH = 3'd1,
    DIR_EAST  = 3'd2,
    DIR_WEST  = 3'd3,
    DIR_LOCAL = 3'd4
  } dir_e;

endpackage

// File: rtl/input_port_router_xy_route_decode.sv
// rtl/input_port_router_xy_route_decode.sv - XY dimension-order route decode to a one-hot target select
module xy_route_decode
  import input_port_router_pkg::*;
#(
  parameter int NET_ADDR_W = NET_ADDR_W_DEF
) (
  input  logic [NET_ADDR_W-1:0] myAddr,
  input  logic [NET_ADDR_W-1:0] dn,
  output logic [NUM_DIRS-1:0]   sel
);

  localparam int HALF = NET_ADDR_W / 2;

  logic [HALF-1:0]            dx, mx;
  logic [NET_ADDR_W-HALF-1:0] dy, my;

  assign dx = dn[HALF-1:0];
  assign dy = dn[NET_ADDR_W-1:HALF];
  assign mx = myAddr[HALF-1:0];
  assign my = myAddr[NET_ADDR_W-1:HALF];

  // X is resolved first; Y only once the packet is in the right column.
  always_comb begin
    sel = '0;
    if (dx > mx)      sel[DIR_EAST]  = 1'b1;
    else if (dx < mx) sel[DIR_WEST]  = 1'b1;
    else if (dy > my) sel[DIR_SOUTH] = 1'b1;
    else if (dy < my) sel[DIR_NORTH] = 1'b1;
    else              sel[DIR_LOCAL] = 1'b1;
  end

endmodule

// File: rtl/input_port_router.sv
// rtl/input_port_router.sv - router input port: packet FIFO with fall-through head and XY route select
// Optional PKT_CHECK_EN: drop packets with readIn == writeIn and flag sticky malformedError.
module input_port_router
  import input_port_router_pkg::*;
#(
  parameter int NET_ADDR_W  = NET_ADDR_W_DEF,
  parameter int BANK_ADDR_W = BANK_ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int DEPTH       = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NET_ADDR_W-1:0]         myAddr,
  input  logic                          inValid,
  output logic                          inReady,
`ifdef PKT_CHECK_EN
  output logic                          malformedError,
`endif
  input  logic [NET_ADDR_W+BANK_ADDR_W-1:0] destAddrIn,
  input  logic [NET_ADDR_W-1:0]         reqAddrIn,
  input  logic                          readIn,
  input  logic                          writeIn,
  input  logic [DATA_W-1:0]             dataIn,
  output logic                          selectBit_NORTH,
  output logic                          selectBit_SOUTH,
  output logic                          selectBit_EAST,
  output logic                          selectBit_WEST,
  output logic                          selectLocal,
  input  logic                          grant_NORTH,
  input  logic                          grant_SOUTH,
  input  logic                          grant_EAST,
  input  logic                          grant_WEST,
  input  logic                          grantLocal,
  output logic [NET_ADDR_W+BANK_ADDR_W-1:0] destAddrOut,
  output logic [NET_ADDR_W-1:0]         reqAddrOut,
  output logic                          readOut,
  output logic                          writeOut,
  output logic [DATA_W-1:0]             dataOut
);

  localparam int DEST_W = NET_ADDR_W + BANK_ADDR_W;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [DEST_W-1:0]     memDest  [DEPTH];
  logic [NET_ADDR_W-1:0] memReq   [DEPTH];
  logic                  memRead  [DEPTH];
  logic                  memWrite [DEPTH];
  logic [DATA_W-1:0]     memData  [DEPTH];

  logic [PTR_W-1:0]    wrPtr, rdPtr;
  logic [CNT_W-1:0]    count;
  logic                notEmpty, push, store, pop;
  logic [NUM_DIRS-1:0] route, sel, grants;

  assign inReady  = (count != FULL_CNT);
  assign notEmpty = (count != '0);
  assign push     = inValid && inReady;

`ifdef PKT_CHECK_EN
  assign store = push && (readIn != writeIn);

  always_ff @(posedge clk) begin
    if (reset)                              malformedError <= 1'b0;
    else if (push && (readIn == writeIn))   malformedError <= 1'b1;
  end
`else
  assign store = push;
`endif

  xy_route_decode #(.NET_ADDR_W(NET_ADDR_W)) uRouteDecode (
    .myAddr (myAddr),
    .dn     (memDest[rdPtr][DEST_W-1 -: NET_ADDR_W]),
    .sel    (route)
  );

  // Decoder output is meaningless on a stale slot, so gate it with occupancy.
  assign sel = notEmpty ? route : '0;

  assign selectBit_NORTH = sel[DIR_NORTH];
  assign selectBit_SOUTH = sel[DIR_SOUTH];
  assign selectBit_EAST  = sel[DIR_EAST];
  assign selectBit_WEST  = sel[DIR_WEST];
  assign selectLocal     = sel[DIR_LOCAL];

  always_comb begin
    grants            = '0;
    grants[DIR_NORTH] = grant_NORTH;
    grants[DIR_SOUTH] = grant_SOUTH;
    grants[DIR_EAST]  = grant_EAST;
    grants[DIR_WEST]  = grant_WEST;
    grants[DIR_LOCAL] = grantLocal;
  end

  assign pop = |(sel & grants);

  assign destAddrOut = notEmpty ? memDest[rdPtr]  : '0;
  assign reqAddrOut  = notEmpty ? memReq[rdPtr]   : '0;
  assign readOut     = notEmpty ? memRead[rdPtr]  : 1'b0;
  assign writeOut    = notEmpty ? memWrite[rdPtr] : 1'b0;
  assign dataOut     = notEmpty ? memData[rdPtr]  : '0;

  always_ff @(posedge clk) begin
    if (store) begin
      memDest[wrPtr]  <= destAddrIn;
      memReq[wrPtr]   <= reqAddrIn;
      memRead[wrPtr]  <= readIn;
      memWrite[wrPtr] <= writeIn;
      memData[wrPtr]  <= dataIn;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (store) wrPtr <= (wrPtr == LAST_PTR) ? '0 : wrPtr + PTR_W'(1);
      if (pop)   rdPtr <= (rdPtr == LAST_PTR) ? '0 : rdPtr + PTR_W'(1);
      case ({store, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_input_port_router.sv
// tb/tb_input_port_router.sv - directed vector bench for input_port_router
module tb_input_port_router;

  localparam logic [4:0] G_0 = 5'b00000;
  localparam logic [4:0] G_N = 5'b00001;
  localparam logic [4:0] G_S = 5'b00010;
  localparam logic [4:0] G_E = 5'b00100;
  localparam logic [4:0] G_W = 5'b01000;
  localparam logic [4:0] G_L = 5'b10000;
  localparam logic [3:0] NET_E = 4'b0110;
  localparam logic [3:0] NET_W = 4'b0100;

  logic        clk, reset;
  logic [3:0]  myAddr;
  logic        inValid, inReady;
  logic [11:0] destAddrIn, destAddrOut;
  logic [3:0]  reqAddrIn, reqAddrOut;
  logic        readIn, writeIn, readOut, writeOut;
  logic [31:0] dataIn, dataOut;
  logic        selectBit_NORTH, selectBit_SOUTH, selectBit_EAST, selectBit_WEST, selectLocal;
  logic        grant_NORTH, grant_SOUTH, grant_EAST, grant_WEST, grantLocal;
`ifdef PKT_CHECK_EN
  logic        malformedError;
`endif

  int nVec = 0;
  int nBad = 0;

  input_port_router dut (
    .clk(clk), .reset(reset), .myAddr(myAddr),
    .inValid(inValid), .inReady(inReady),
`ifdef PKT_CHECK_EN
    .malformedError(malformedError),
`endif
    .destAddrIn(destAddrIn), .reqAddrIn(reqAddrIn), .readIn(readIn), .writeIn(writeIn), .dataIn(dataIn),
    .selectBit_NORTH(selectBit_NORTH), .selectBit_SOUTH(selectBit_SOUTH), .selectBit_EAST(selectBit_EAST),
    .selectBit_WEST(selectBit_WEST), .selectLocal(selectLocal),
    .grant_NORTH(grant_NORTH), .grant_SOUTH(grant_SOUTH), .grant_EAST(grant_EAST),
    .grant_WEST(grant_WEST), .grantLocal(grantLocal),
    .destAddrOut(destAddrOut), .reqAddrOut(reqAddrOut), .readOut(readOut), .writeOut(writeOut), .dataOut(dataOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected finish");
    $fatal(1);
  end

  typedef struct {
    logic        push;
    logic [3:0]  net;
    logic [31:0] data;
    logic [4:0]  grant;
    logic        expReady;
    logic [4:0]  expSel;
    logic [3:0]  expNet;
    logic [31:0] expData;
  } vec_t;

  vec_t tbl [8];

  function automatic logic [4:0] selVec();
    return {selectLocal, selectBit_WEST, selectBit_EAST, selectBit_SOUTH, selectBit_NORTH};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nVec++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] net, input logic [31:0] d,
                       input logic rd, input logic wr, input logic [4:0] g);
    inValid    = v;
    destAddrIn = {net, d[7:0]};
    reqAddrIn  = d[3:0];
    readIn     = rd;
    writeIn    = wr;
    dataIn     = d;
    {grantLocal, grant_WEST, grant_EAST, grant_SOUTH, grant_NORTH} = g;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    myAddr = 4'b0101;
    drive(1'b0, 4'h0, 32'h0, 1'b1, 1'b0, G_0);
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;

    // reset state
    @(negedge clk);
    chk("reset inReady", inReady, 1);
    chk("reset sel", selVec(), 0);
    chk("reset data", dataOut, 0);
    chk("reset dest", destAddrOut, 0);

    // tests 1 and 2: one of each route through a single-entry stream
    tbl[0] = '{1'b1, NET_E,   32'hA1, G_E, 1'b1, G_0, 4'h0,    32'h0};
    tbl[1] = '{1'b0, 4'h0,    32'h0,  G_E, 1'b1, G_E, NET_E,   32'hA1};
    tbl[2] = '{1'b1, NET_W,   32'hB2, G_0, 1'b1, G_0, 4'h0,    32'h0};
    tbl[3] = '{1'b1, 4'b1001, 32'hC3, G_W, 1'b1, G_W, NET_W,   32'hB2};
    tbl[4] = '{1'b1, 4'b0001, 32'hD4, G_S, 1'b1, G_S, 4'b1001, 32'hC3};
    tbl[5] = '{1'b1, 4'b0101, 32'hE5, G_N, 1'b1, G_N, 4'b0001, 32'hD4};
    tbl[6] = '{1'b0, 4'h0,    32'h0,  G_L, 1'b1, G_L, 4'b0101, 32'hE5};
    tbl[7] = '{1'b0, 4'h0,    32'h0,  G_0, 1'b1, G_0, 4'h0,    32'h0};
    step();
    for (int i = 0; i < 8; i++) begin
      drive(tbl[i].push, tbl[i].net, tbl[i].data, 1'b1, 1'b0, tbl[i].grant);
      @(negedge clk);
      chk($sformatf("route[%0d] inReady", i), inReady, tbl[i].expReady);
      chk($sformatf("route[%0d] sel", i), selVec(), tbl[i].expSel);
      chk($sformatf("route[%0d] data", i), dataOut, tbl[i].expData);
      chk($sformatf("route[%0d] dest", i), destAddrOut, {tbl[i].expNet, tbl[i].expData[7:0]});
      chk($sformatf("route[%0d] req", i), reqAddrOut, tbl[i].expData[3:0]);
      step();
    end

    // test 3: fill, backpressure, single pop, in-order drain
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, NET_E, 32'h100 + i, 1'b1, 1'b0, G_0);
      @(negedge clk);
      chk($sformatf("fill[%0d] inReady", i), inReady, (i < 4) ? 1 : 0);
      step();
    end
    drive(1'b1, NET_E, 32'h104, 1'b1, 1'b0, G_E);
    @(negedge clk);
    chk("full inReady", inReady, 0);
    chk("full sel", selVec(), G_E);
    chk("full head", dataOut, 32'h100);
    step();
    drive(1'b1, NET_E, 32'h104, 1'b1, 1'b0, G_0);
    @(negedge clk);
    chk("after pop inReady", inReady, 1);
    chk("after pop head", dataOut, 32'h101);
    step();
    for (int i = 1; i < 5; i++) begin
      drive(1'b0, 4'h0, 32'h0, 1'b1, 1'b0, G_E);
      @(negedge clk);
      chk($sformatf("drain[%0d] data", i), dataOut, 32'h100 + i);
      step();
    end
    @(negedge clk);
    chk("drained sel", selVec(), 0);
    chk("drained inReady", inReady, 1);

    // test 4: steady push+pop at count 2, pointers wrap
    step();
    drive(1'b1, NET_E, 32'd0, 1'b1, 1'b0, G_0);
    step();
    drive(1'b1, NET_E, 32'd1, 1'b1, 1'b0, G_0);
    step();
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, NET_E, 32'd2 + i, 1'b1, 1'b0, G_E);
      @(negedge clk);
      chk($sformatf("stream[%0d] inReady", i), inReady, 1);
      chk($sformatf("stream[%0d] sel", i), selVec(), G_E);
      chk($sformatf("stream[%0d] data", i), dataOut, i);
      step();
    end
    drive(1'b0, 4'h0, 32'h0, 1'b1, 1'b0, G_E);
    @(negedge clk);
    chk("stream tail0", dataOut, 10);
    step();
    @(negedge clk);
    chk("stream tail1", dataOut, 11);
    step();
    @(negedge clk);
    chk("stream empty sel", selVec(), 0);

    // test 5: wrong grant does not pop, reset discards buffered packets
    drive(1'b0, 4'h0, 32'h0, 1'b1, 1'b0, G_0);
    doReset();
    drive(1'b1, NET_W, 32'h55, 1'b1, 1'b0, G_0);
    step();
    drive(1'b1, NET_W, 32'h66, 1'b1, 1'b0, G_0);
    step();
    drive(1'b1, NET_W, 32'h77, 1'b1, 1'b0, G_E);
    @(negedge clk);
    chk("wrong grant sel", selVec(), G_W);
    chk("wrong grant head", dataOut, 32'h55);
    step();
    drive(1'b0, 4'h0, 32'h0, 1'b1, 1'b0, G_E);
    @(negedge clk);
    chk("wrong grant no pop", dataOut, 32'h55);
    doReset();
    @(negedge clk);
    chk("mid reset sel", selVec(), 0);
    chk("mid reset data", dataOut, 0);
    chk("mid reset dest", destAddrOut, 0);
    chk("mid reset inReady", inReady, 1);
    step();
    @(negedge clk);
    chk("post reset still empty", selVec(), 0);

`ifdef PKT_CHECK_EN
    // test 6: malformed packets are dropped and flagged
    chk("malformed reset", malformedError, 0);
    drive(1'b1, NET_E, 32'h99, 1'b1, 1'b1, G_0);
    @(negedge clk);
    chk("malformed inReady", inReady, 1);
    step();
    drive(1'b0, 4'h0, 32'h0, 1'b1, 1'b0, G_0);
    @(negedge clk);
    chk("malformed dropped", selVec(), 0);
    chk("malformed flag", malformedError, 1);
    drive(1'b1, NET_E, 32'h88, 1'b1, 1'b0, G_0);
    step();
    drive(1'b0, 4'h0, 32'h0, 1'b1, 1'b0, G_E);
    @(negedge clk);
    chk("valid after malformed sel", selVec(), G_E);
    chk("valid after malformed data", dataOut, 32'h88);
    chk("malformed sticky", malformedError, 1);
    step();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
    $finish;
  end

endmodule
